// File: rtl/udp_demux_core_if.sv
// UDP frame bundle: header handshake, header fields, payload stream.
// N is the number of channels; every bus is N slices wide.
interface udp_demux_core_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [N-1:0]            udp_hdr_valid;
    logic [N-1:0]            udp_hdr_ready;
    logic [N*48-1:0]         eth_dest_mac;
    logic [N*48-1:0]         eth_src_mac;
    logic [N*16-1:0]         eth_type;
    logic [N*4-1:0]          ip_version;
    logic [N*4-1:0]          ip_ihl;
    logic [N*6-1:0]          ip_dscp;
    logic [N*2-1:0]          ip_ecn;
    logic [N*16-1:0]         ip_length;
    logic [N*16-1:0]         ip_identification;
    logic [N*3-1:0]          ip_flags;
    logic [N*13-1:0]         ip_fragment_offset;
    logic [N*8-1:0]          ip_ttl;
    logic [N*8-1:0]          ip_protocol;
    logic [N*16-1:0]         ip_header_checksum;
    logic [N*32-1:0]         ip_source_ip;
    logic [N*32-1:0]         ip_dest_ip;
    logic [N*16-1:0]         udp_source_port;
    logic [N*16-1:0]         udp_dest_port;
    logic [N*16-1:0]         udp_length;
    logic [N*16-1:0]         udp_checksum;
    logic [N*DATA_WIDTH-1:0] udp_payload_axis_tdata;
    logic [N*KEEP_WIDTH-1:0] udp_payload_axis_tkeep;
    logic [N-1:0]            udp_payload_axis_tvalid;
    logic [N-1:0]            udp_payload_axis_tready;
    logic [N-1:0]            udp_payload_axis_tlast;
    logic [N*ID_WIDTH-1:0]   udp_payload_axis_tid;
    logic [N*DEST_WIDTH-1:0] udp_payload_axis_tdest;
    logic [N*USER_WIDTH-1:0] udp_payload_axis_tuser;

    modport master (
        output udp_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
        output ip_version, ip_ihl, ip_dscp, ip_ecn, ip_length,
        output ip_identification, ip_flags, ip_fragment_offset,
        output ip_ttl, ip_protocol, ip_header_checksum,
        output ip_source_ip, ip_dest_ip,
        output udp_source_port, udp_dest_port, udp_length, udp_checksum,
        output udp_payload_axis_tdata, udp_payload_axis_tkeep,
        output udp_payload_axis_tvalid, udp_payload_axis_tlast,
        output udp_payload_axis_tid, udp_payload_axis_tdest,
        output udp_payload_axis_tuser,
        input  udp_hdr_ready, udp_payload_axis_tready
    );

    modport slave (
        input  udp_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
        input  ip_version, ip_ihl, ip_dscp, ip_ecn, ip_length,
        input  ip_identification, ip_flags, ip_fragment_offset,
        input  ip_ttl, ip_protocol, ip_header_checksum,
        input  ip_source_ip, ip_dest_ip,
        input  udp_source_port, udp_dest_port, udp_length, udp_checksum,
        input  udp_payload_axis_tdata, udp_payload_axis_tkeep,
        input  udp_payload_axis_tvalid, udp_payload_axis_tlast,
        input  udp_payload_axis_tid, udp_payload_axis_tdest,
        input  udp_payload_axis_tuser,
        output udp_hdr_ready, udp_payload_axis_tready
    );
endinterface

// File: rtl/udp_demux_core.sv
// Routes one UDP frame (header + payload) to one of M_COUNT channels.
// Header and payload are registered; payload uses an output + skid pair.
module udp_demux_core #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    localparam int SW = ($clog2(M_COUNT) > 1) ? $clog2(M_COUNT) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    udp_demux_core_if.slave  s,
    udp_demux_core_if.master m,
    input  logic          enable,
    input  logic          drop,
    input  logic [SW-1:0] select
);
    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [47:0] eth_src_mac;
        logic [15:0] eth_type;
        logic [3:0]  ip_version;
        logic [3:0]  ip_ihl;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [15:0] ip_length;
        logic [15:0] ip_identification;
        logic [2:0]  ip_flags;
        logic [12:0] ip_fragment_offset;
        logic [7:0]  ip_ttl;
        logic [7:0]  ip_protocol;
        logic [15:0] ip_header_checksum;
        logic [31:0] ip_source_ip;
        logic [31:0] ip_dest_ip;
        logic [15:0] udp_source_port;
        logic [15:0] udp_dest_port;
        logic [15:0] udp_length;
        logic [15:0] udp_checksum;
    } hdr_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } pl_t;

    localparam logic [SW:0]         MC  = (SW+1)'(M_COUNT);
    localparam logic [M_COUNT-1:0] ONE = M_COUNT'(1);

    state_t             r_state, w_state_next;
    logic [SW-1:0]      r_sel;
    logic               r_drop;
    logic [M_COUNT-1:0] r_hdr_valid;
    hdr_t               r_hdr, w_hdr_in;
    logic               w_hdr_ready, w_hdr_hs;
    logic               w_drop_in, w_drop_next;

    logic               r_s_tready, w_s_tready;
    logic               w_in_valid, w_out_ready, w_ready_early;
    logic               r_m_valid, r_t_valid;
    logic               w_m_valid_nx, w_t_valid_nx;
    logic               w_in2out, w_in2tmp, w_tmp2out;
    logic [SW-1:0]      r_m_ch, r_t_ch;
    pl_t                r_m_pl, r_t_pl, w_pl_in;

    assign w_hdr_hs    = w_hdr_ready && s.udp_hdr_valid;
    assign w_drop_in   = drop || ({1'b0, select} >= MC);
    assign w_drop_next = w_hdr_hs ? w_drop_in : r_drop;

    assign w_hdr_in = '{
        eth_dest_mac:       s.eth_dest_mac,
        eth_src_mac:        s.eth_src_mac,
        eth_type:           s.eth_type,
        ip_version:         s.ip_version,
        ip_ihl:             s.ip_ihl,
        ip_dscp:            s.ip_dscp,
        ip_ecn:             s.ip_ecn,
        ip_length:          s.ip_length,
        ip_identification:  s.ip_identification,
        ip_flags:           s.ip_flags,
        ip_fragment_offset: s.ip_fragment_offset,
        ip_ttl:             s.ip_ttl,
        ip_protocol:        s.ip_protocol,
        ip_header_checksum: s.ip_header_checksum,
        ip_source_ip:       s.ip_source_ip,
        ip_dest_ip:         s.ip_dest_ip,
        udp_source_port:    s.udp_source_port,
        udp_dest_port:      s.udp_dest_port,
        udp_length:         s.udp_length,
        udp_checksum:       s.udp_checksum
    };

    always_comb begin
        w_pl_in.data = s.udp_payload_axis_tdata;
        w_pl_in.keep = (KEEP_ENABLE != 0) ? s.udp_payload_axis_tkeep : '1;
        w_pl_in.last = s.udp_payload_axis_tlast;
        w_pl_in.id   = (ID_ENABLE != 0)   ? s.udp_payload_axis_tid   : '0;
        w_pl_in.dest = (DEST_ENABLE != 0) ? s.udp_payload_axis_tdest : '0;
        w_pl_in.user = (USER_ENABLE != 0) ? s.udp_payload_axis_tuser : '0;
    end

    // Frame FSM; a dropped frame is swallowed with tready held high.
    always_comb begin
        w_state_next = r_state;
        w_hdr_ready  = 1'b0;
        w_s_tready   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_hdr_ready = reset_n && enable && !(|r_hdr_valid);
                if (w_hdr_ready && s.udp_hdr_valid)
                    w_state_next = FRAME;
            end
            FRAME: begin
                w_s_tready = r_drop || r_s_tready;
                if (w_s_tready && s.udp_payload_axis_tvalid &&
                    s.udp_payload_axis_tlast)
                    w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_drop      <= 1'b0;
            r_hdr_valid <= '0;
            r_hdr       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_hdr_hs) begin
                r_sel       <= select;
                r_drop      <= w_drop_in;
                r_hdr       <= w_hdr_in;
                r_hdr_valid <= w_drop_in ? '0 : (ONE << select);
            end else begin
                r_hdr_valid <= r_hdr_valid & ~m.udp_hdr_ready;
            end
        end
    end

    // Each held beat carries its own channel so draining beats are
    // unaffected by the next frame's select.
    always_comb begin
        w_m_valid_nx  = r_m_valid;
        w_t_valid_nx  = r_t_valid;
        w_in2out      = 1'b0;
        w_in2tmp      = 1'b0;
        w_tmp2out     = 1'b0;
        w_out_ready   = m.udp_payload_axis_tready[r_m_ch];
        w_in_valid    = s.udp_payload_axis_tvalid && r_s_tready;
        w_ready_early = w_out_ready ||
                        (!r_t_valid && (!r_m_valid || !w_in_valid));
        if (r_s_tready) begin
            if (w_out_ready || !r_m_valid) begin
                w_m_valid_nx = w_in_valid;
                w_in2out     = 1'b1;
            end else begin
                w_t_valid_nx = w_in_valid;
                w_in2tmp     = 1'b1;
            end
        end else if (w_out_ready) begin
            w_m_valid_nx = r_t_valid;
            w_t_valid_nx = 1'b0;
            w_tmp2out    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_tready <= 1'b0;
            r_m_valid  <= 1'b0;
            r_t_valid  <= 1'b0;
            r_m_ch     <= '0;
            r_t_ch     <= '0;
            r_m_pl     <= '0;
            r_t_pl     <= '0;
        end else begin
            r_s_tready <= w_ready_early && (w_state_next == FRAME) &&
                          !w_drop_next;
            r_m_valid  <= w_m_valid_nx;
            r_t_valid  <= w_t_valid_nx;
            if (w_in2out) begin
                r_m_pl <= w_pl_in;
                r_m_ch <= r_sel;
            end else if (w_tmp2out) begin
                r_m_pl <= r_t_pl;
                r_m_ch <= r_t_ch;
            end
            if (w_in2tmp) begin
                r_t_pl <= w_pl_in;
                r_t_ch <= r_sel;
            end
        end
    end

    assign s.udp_hdr_ready           = w_hdr_ready;
    assign s.udp_payload_axis_tready = w_s_tready;

    assign m.udp_hdr_valid      = r_hdr_valid;
    assign m.eth_dest_mac       = {M_COUNT{r_hdr.eth_dest_mac}};
    assign m.eth_src_mac        = {M_COUNT{r_hdr.eth_src_mac}};
    assign m.eth_type           = {M_COUNT{r_hdr.eth_type}};
    assign m.ip_version         = {M_COUNT{r_hdr.ip_version}};
    assign m.ip_ihl             = {M_COUNT{r_hdr.ip_ihl}};
    assign m.ip_dscp            = {M_COUNT{r_hdr.ip_dscp}};
    assign m.ip_ecn             = {M_COUNT{r_hdr.ip_ecn}};
    assign m.ip_length          = {M_COUNT{r_hdr.ip_length}};
    assign m.ip_identification  = {M_COUNT{r_hdr.ip_identification}};
    assign m.ip_flags           = {M_COUNT{r_hdr.ip_flags}};
    assign m.ip_fragment_offset = {M_COUNT{r_hdr.ip_fragment_offset}};
    assign m.ip_ttl             = {M_COUNT{r_hdr.ip_ttl}};
    assign m.ip_protocol        = {M_COUNT{r_hdr.ip_protocol}};
    assign m.ip_header_checksum = {M_COUNT{r_hdr.ip_header_checksum}};
    assign m.ip_source_ip       = {M_COUNT{r_hdr.ip_source_ip}};
    assign m.ip_dest_ip         = {M_COUNT{r_hdr.ip_dest_ip}};
    assign m.udp_source_port    = {M_COUNT{r_hdr.udp_source_port}};
    assign m.udp_dest_port      = {M_COUNT{r_hdr.udp_dest_port}};
    assign m.udp_length         = {M_COUNT{r_hdr.udp_length}};
    assign m.udp_checksum       = {M_COUNT{r_hdr.udp_checksum}};

    assign m.udp_payload_axis_tvalid =
        {{(M_COUNT-1){1'b0}}, r_m_valid} << r_m_ch;
    assign m.udp_payload_axis_tdata = {M_COUNT{r_m_pl.data}};
    assign m.udp_payload_axis_tkeep = {M_COUNT{r_m_pl.keep}};
    assign m.udp_payload_axis_tlast = {M_COUNT{r_m_pl.last}};
    assign m.udp_payload_axis_tid   = {M_COUNT{r_m_pl.id}};
    assign m.udp_payload_axis_tdest = {M_COUNT{r_m_pl.dest}};
    assign m.udp_payload_axis_tuser = {M_COUNT{r_m_pl.user}};
endmodule

// File: tb/tb_udp_demux_core.sv
// Scoreboard bench for udp_demux_core: routing, drop, backpressure,
// enable gating, header drain ordering and asynchronous reset.
module tb_udp_demux_core;
    localparam int M = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       drop;
    logic [1:0] select;

    always #5 clk = ~clk;

    udp_demux_core_if #(.N(1)) s_if();
    udp_demux_core_if #(.N(M)) m_if();

    udp_demux_core #(.M_COUNT(M)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .s      (s_if),
        .m      (m_if),
        .enable (enable),
        .drop   (drop),
        .select (select)
    );

    logic [M-1:0] hrdy;
    logic [M-1:0] trdy;
    logic         pat_en;
    logic         pat_bit;

    assign m_if.udp_hdr_ready = hrdy;
    assign m_if.udp_payload_axis_tready =
        pat_en ? {trdy[3:2], pat_bit, trdy[0]} : trdy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic lat_chk = 1'b0;
    logic prev_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
        int         c;
    } beat_t;

    beat_t       pq[M][$];
    logic [47:0] hq[M][$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Channel ch1 tready sequence 1,0,0,1 repeating
    initial begin
        logic [3:0] p;
        int k;
        p = 4'b1001;
        k = 0;
        pat_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pat_bit = p[k % 4];
            k++;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < M; i++) begin
                if (m_if.udp_hdr_valid[i] && m_if.udp_hdr_ready[i]) begin
                    if (hq[i].size() == 0) begin
                        check("hdr_spur", hq[i].size(), 1);
                    end else begin
                        logic [47:0] eh;
                        int j;
                        eh = hq[i].pop_front();
                        j = (i + 1) % M;
                        check("hdr_fld",
                              {m_if.udp_source_port[16*i +: 16],
                               m_if.ip_dest_ip[32*i +: 32]}, eh);
                        check("hdr_bcast",
                              m_if.udp_source_port[16*j +: 16], eh[47:32]);
                    end
                end
                if (m_if.udp_payload_axis_tvalid[i] &&
                    m_if.udp_payload_axis_tready[i]) begin
                    if (pq[i].size() == 0) begin
                        check("beat_spur", pq[i].size(), 1);
                    end else begin
                        beat_t e;
                        e = pq[i].pop_front();
                        check("beat",
                              {m_if.udp_payload_axis_tdata[8*i +: 8],
                               m_if.udp_payload_axis_tlast[i],
                               m_if.udp_payload_axis_tuser[i],
                               m_if.udp_payload_axis_tid[8*i +: 8],
                               m_if.udp_payload_axis_tdest[8*i +: 8],
                               m_if.udp_payload_axis_tkeep[i]},
                              {e.d, e.l, e.u, 8'h00, 8'h00, 1'b1});
                        if (lat_chk) check("lat", cyc - e.c, 1);
                    end
                end
            end
            if (pat_en && prev_bp)
                check("bp_rdy", s_if.udp_payload_axis_tready, 0);
            prev_bp = pat_en &&
                |(m_if.udp_payload_axis_tvalid &
                  ~m_if.udp_payload_axis_tready) &&
                s_if.udp_payload_axis_tvalid &&
                s_if.udp_payload_axis_tready;
        end else begin
            prev_bp = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input logic [15:0] sp, input logic [31:0] dip);
        s_if.eth_dest_mac       = 48'h0a0b0c0d0e0f;
        s_if.eth_src_mac        = 48'h102030405060;
        s_if.eth_type           = 16'h0800;
        s_if.ip_version         = 4'h4;
        s_if.ip_ihl             = 4'h5;
        s_if.ip_dscp            = 6'h0;
        s_if.ip_ecn             = 2'h0;
        s_if.ip_length          = 16'h0030;
        s_if.ip_identification  = sp ^ 16'hffff;
        s_if.ip_flags           = 3'h2;
        s_if.ip_fragment_offset = 13'h0;
        s_if.ip_ttl             = 8'h40;
        s_if.ip_protocol        = 8'h11;
        s_if.ip_header_checksum = 16'hbeef;
        s_if.ip_source_ip       = 32'hc0a80001;
        s_if.ip_dest_ip         = dip;
        s_if.udp_source_port    = sp;
        s_if.udp_dest_port      = 16'd5000;
        s_if.udp_length         = 16'd16;
        s_if.udp_checksum       = 16'h0;
    endtask

    task automatic send_hdr(input logic [1:0] sel, input logic drp,
                            input logic [15:0] sp);
        int t;
        logic [31:0] dip;
        logic [3:0] oh;
        t = 0;
        dip = {16'hc0a8, sp};
        oh = 4'b0001 << sel;
        set_hdr(sp, dip);
        select = sel;
        drop = drp;
        s_if.udp_hdr_valid = 1'b1;
        if (!drp) hq[sel].push_back({sp, dip});
        @(negedge clk);
        while (!s_if.udp_hdr_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) check("hdr_to", t, 0);
        @(posedge clk);
        #1;
        s_if.udp_hdr_valid = 1'b0;
        select = ~sel;
        drop = ~drp;
        check("hdr_vld", m_if.udp_hdr_valid, drp ? 4'b0000 : oh);
    endtask

    task automatic send_beats(input logic [1:0] sel, input logic drp,
                              input int n, input logic [7:0] base,
                              input logic last_on);
        for (int b = 0; b < n; b++) begin
            int t;
            logic [7:0] d;
            logic l;
            t = 0;
            d = base + 8'(b) * 8'h11;
            l = last_on && (b == n - 1);
            s_if.udp_payload_axis_tdata  = d;
            s_if.udp_payload_axis_tlast  = l;
            s_if.udp_payload_axis_tuser  = d[0];
            s_if.udp_payload_axis_tid    = 8'($urandom);
            s_if.udp_payload_axis_tdest  = 8'($urandom);
            s_if.udp_payload_axis_tkeep  = 1'b0;
            s_if.udp_payload_axis_tvalid = 1'b1;
            @(negedge clk);
            while (!s_if.udp_payload_axis_tready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) check("beat_to", t, 0);
            if (drp) begin
                check("drop_wait", t, 0);
                check("drop_mv", {m_if.udp_hdr_valid,
                                  m_if.udp_payload_axis_tvalid}, 0);
            end else begin
                pq[sel].push_back('{d, l, d[0], cyc});
            end
            @(posedge clk);
            #1;
        end
        s_if.udp_payload_axis_tvalid = 1'b0;
        s_if.udp_payload_axis_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        drop    = 1'b0;
        select  = 2'd0;
        hrdy    = 4'hf;
        trdy    = 4'hf;
        pat_en  = 1'b0;
        s_if.udp_hdr_valid = 1'b0;
        s_if.udp_payload_axis_tvalid = 1'b0;
        s_if.udp_payload_axis_tlast  = 1'b0;
        s_if.udp_payload_axis_tdata  = 8'h0;
        s_if.udp_payload_axis_tkeep  = 1'b0;
        s_if.udp_payload_axis_tid    = 8'h0;
        s_if.udp_payload_axis_tdest  = 8'h0;
        s_if.udp_payload_axis_tuser  = 1'b0;
        set_hdr(16'h0, 32'h0);
        idle(3);
        check("rst_hv", m_if.udp_hdr_valid, 0);
        check("rst_tv", m_if.udp_payload_axis_tvalid, 0);
        check("rst_hrdy", s_if.udp_hdr_ready, 0);
        check("rst_trdy", s_if.udp_payload_axis_tready, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_hrdy", s_if.udp_hdr_ready, 1);
        idle(1);

        lat_chk = 1'b1;
        send_hdr(2'd2, 1'b0, 16'h1234);
        send_beats(2'd2, 1'b0, 3, 8'h11, 1'b1);
        idle(1);
        lat_chk = 1'b0;
        idle(3);

        send_hdr(2'd1, 1'b1, 16'h5555);
        send_beats(2'd1, 1'b1, 4, 8'h40, 1'b1);
        send_hdr(2'd0, 1'b0, 16'h0a0a);
        send_beats(2'd0, 1'b0, 3, 8'h50, 1'b1);
        idle(4);

        pat_en = 1'b1;
        send_hdr(2'd1, 1'b0, 16'h0101);
        send_beats(2'd1, 1'b0, 6, 8'h60, 1'b1);
        idle(10);
        pat_en = 1'b0;

        enable = 1'b0;
        fork
            send_hdr(2'd3, 1'b0, 16'h0303);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("en0_rdy", s_if.udp_hdr_ready, 0);
                end
                @(posedge clk);
                #1;
                enable = 1'b1;
            end
        join
        send_beats(2'd3, 1'b0, 2, 8'h70, 1'b1);
        idle(4);

        hrdy[0] = 1'b0;
        send_hdr(2'd0, 1'b0, 16'h0c0c);
        send_beats(2'd0, 1'b0, 2, 8'h80, 1'b1);
        fork
            send_hdr(2'd3, 1'b0, 16'h3c3c);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("hold_rdy", s_if.udp_hdr_ready, 0);
                end
                @(posedge clk);
                #1;
                hrdy[0] = 1'b1;
            end
        join
        send_beats(2'd3, 1'b0, 2, 8'h90, 1'b1);
        idle(4);

        hrdy[2] = 1'b0;
        trdy[2] = 1'b0;
        send_hdr(2'd2, 1'b0, 16'h2222);
        send_beats(2'd2, 1'b0, 2, 8'ha0, 1'b0);
        check("pre_hv", m_if.udp_hdr_valid, 4'b0100);
        check("pre_tv", m_if.udp_payload_axis_tvalid, 4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_hv", m_if.udp_hdr_valid, 0);
        check("arst_tv", m_if.udp_payload_axis_tvalid, 0);
        pq[2].delete();
        hq[2].delete();
        hrdy = 4'hf;
        trdy = 4'hf;
        idle(2);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_hrdy", s_if.udp_hdr_ready, 1);
        idle(1);
        send_hdr(2'd1, 1'b0, 16'h7777);
        send_beats(2'd1, 1'b0, 2, 8'hb0, 1'b1);
        idle(6);

        for (int i = 0; i < M; i++)
            check("q_empty", pq[i].size() + hq[i].size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/udp_demux_core.md
Name: udp_demux_core

Overview:
Routes one UDP frame stream (header plus AXI-Stream payload) to one of M_COUNT output channels. The target is chosen per frame by the `select` input, and the frame can also be discarded with `drop`. It sits in the Ethernet RX path between the UDP stack and per-port consumers. All output buses are flattened: channel i occupies slice [W*i+W-1 : W*i] of each bus of per-channel width W.

Parameters:
- M_COUNT, 4, number of output channels (>=2); SW = max($clog2(M_COUNT),1).
- DATA_WIDTH, 8, payload tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8), tkeep is used; when 0, tkeep is forced to all-ones.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ID_ENABLE, 0, tid is forwarded when 1, driven 0 when 0.
- ID_WIDTH, 8, tid width.
- DEST_ENABLE, 0, tdest is forwarded when 1, driven 0 when 0.
- DEST_WIDTH, 8, tdest width.
- USER_ENABLE, 1, tuser is forwarded when 1, driven 0 when 0.
- USER_WIDTH, 1, tuser width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- s_udp_hdr_valid / s_udp_hdr_ready  in/out  1  input header handshake.
- s_eth_dest_mac, s_eth_src_mac, s_eth_type  in  48,48,16  Ethernet header fields.
- s_ip_version, s_ip_ihl, s_ip_dscp, s_ip_ecn, s_ip_length, s_ip_identification, s_ip_flags, s_ip_fragment_offset, s_ip_ttl, s_ip_protocol, s_ip_header_checksum, s_ip_source_ip, s_ip_dest_ip  in  4,4,6,2,16,16,3,13,8,8,16,32,32  IPv4 header fields.
- s_udp_source_port, s_udp_dest_port, s_udp_length, s_udp_checksum  in  16 each  UDP header fields.
- s_udp_payload_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  DATA_WIDTH,KEEP_WIDTH,1,1,1,ID_WIDTH,DEST_WIDTH,USER_WIDTH  input payload stream.
- m_udp_hdr_valid / m_udp_hdr_ready  out/in  M_COUNT  per-channel header handshake.
- m_<every header field above>  out  M_COUNT*field width  header fields per channel.
- m_udp_payload_axis_*  out (tready in)  M_COUNT*signal width  payload stream per channel.
- enable  in  1  allows a new frame to be accepted.
- drop  in  1  discard the next accepted frame.
- select  in  SW  target channel for the next accepted frame.

Behaviour:
- State: IDLE (frame=0) and FRAME (frame=1). Latched per frame: sel_reg and drop_reg.
- Reset values: frame=0; all m_udp_hdr_valid=0; all m_tvalid=0; skid buffer empty; s_udp_hdr_ready=0; s_tready=0. Data and field registers are don't-care at reset.
- s_udp_hdr_ready is combinational: 1 only when IDLE && enable && no m_udp_hdr_valid bit is set.
- On a header handshake:
  - Capture sel_reg=select and drop_reg=(drop || select>=M_COUNT), then enter FRAME.
  - If not dropping, the next cycle m_udp_hdr_valid[sel_reg]=1, with all header fields registered and presented identically on every channel slice.
  - That valid holds until m_udp_hdr_ready[sel_reg]. Header latency is 1 cycle.
  - If dropping, no header is emitted.
- s_udp_payload_axis_tready:
  - 0 in IDLE.
  - In FRAME with drop_reg=1: 1 (beats are consumed and discarded).
  - In FRAME otherwise: a registered ready, set when m_tready[sel] || (!temp_valid && (!m_tvalid || !s_tvalid)).
  - Header and payload of the same frame are independent. Payload can flow before the header output is consumed.
- Payload path: output register plus one-entry temp (skid) register, per standard AXIS register rules.
  - Latency is 1 cycle. No beat is lost or duplicated under any tready pattern.
  - Only m_tvalid[sel_reg] can be 1. The payload data and sideband signals are broadcast to all channel slices.
  - Sideband fields disabled by parameter are driven to their constants (tkeep all-ones, tid/tdest/tuser 0).
- End of frame: an accepted input beat with tlast=1 returns the block to IDLE at the next edge.
  - A new header is accepted only after the previous header output has drained.
  - Beats still in the skid or output register continue to drain after the return to IDLE.
- Changes to select, drop or enable during FRAME have no effect on the current frame.
- Asserting reset_n low mid-frame immediately clears all valids and state. Partial frames are abandoned.

Test Plan:
- M_COUNT=4, DATA_WIDTH=8, select=2, 3-beat frame 0x11,0x22,0x33 (tlast on 0x33), all m_tready=1 -> m_udp_hdr_valid=4'b0100 one cycle after handshake; beats appear only on channel 2 in order, 1-cycle latency; ch2 src_port equals input.
- drop=1, select=1, 4-beat frame -> s_tready=1 throughout, no m_hdr_valid or m_tvalid asserted; next frame with select=0 delivered normally.
- select=1, m_tready[1] toggled 1,0,0,1 each cycle during a 6-beat frame -> output sequence identical to input, no loss or duplication, s_tready deasserts within 1 cycle of backpressure.
- enable=0 with s_udp_hdr_valid=1 -> s_udp_hdr_ready=0; raise enable -> header accepted next edge.
- Back-to-back frames to ch0 then ch3 while m_udp_hdr_ready[0] is held low for 5 cycles -> second header not accepted until ch0 header consumed, then routed to ch3.
- reset_n low mid-frame -> all m valids 0 asynchronously; after release, s_udp_hdr_ready=1 with enable=1.
